// File: rtl/dot_matrix_scheduler.sv
// 16x16 dot-matrix sequencer: row scan, blanking, ROM fetch
// and round-robin display sharing with hold time and blink.
module dot_matrix_scheduler #(
  parameter int         NREQ         = 2,
  parameter int         SCAN_DIV     = 1000,
  parameter int         BLANK_CYC    = 8,
  parameter int         HOLD_FRAMES  = 25,
  parameter int         BLINK_FRAMES = 16,
  parameter logic [3:0] IDLE_PAT     = 4'd0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_pat,
  input  logic [NREQ-1:0]   req_blink,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       Dot_R,
  output logic [3:0]        Dot_C,
  output logic              frame_tick
);

  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] C_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] C_ONE   = PW'(1);
  localparam logic [PW-1:0] C_BLANK = PW'(BLANK_CYC);
  localparam logic [HW-1:0] H_MAX   = HW'(HOLD_FRAMES);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SCAN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_row;
  logic [3:0]      r_dot_c;
  logic [7:0]      r_rom_addr;
  logic [15:0]     r_row_buf;
  logic [NREQ-1:0] r_grant;
  logic [HW-1:0]   r_hold;
  logic [3:0]      r_pat_l;
  logic            r_blink_l;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_phase;

  logic            w_slot_end;
  logic            w_frame_end;
  logic            w_own_req;
  logic            w_others;
  logic            w_keep;
  logic            w_found;
  int              w_start;
  logic [NREQ-1:0] w_rr;
  logic [NREQ-1:0] w_grant;
  logic [HW-1:0]   w_hold;
  logic [3:0]      w_pat;
  logic            w_blk;
  logic            w_show;

  assign w_slot_end  = (r_presc == C_LAST);
  assign w_frame_end = w_slot_end && (r_row == 4'hF);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (scan_en) w_next = S_ARB;
      S_ARB:   w_next = S_SCAN;
      S_SCAN:  if (w_frame_end) w_next = S_ARB;
      default: w_next = S_IDLE;
    endcase
    if (!scan_en) w_next = S_IDLE;
  end

  assign w_own_req = |(req & r_grant);
  assign w_others  = |(req & ~r_grant);
  assign w_keep    = w_own_req &&
                     ((r_hold < H_MAX) || !w_others);

  // Round-robin search starts just past the current owner.
  always_comb begin
    w_start = 0;
    for (int i = 0; i < NREQ; i++)
      if (r_grant[i]) w_start = (i + 1) % NREQ;
    w_rr    = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!w_found && req[i] &&
            i == (w_start + k) % NREQ) begin
          w_rr[i] = 1'b1;
          w_found = 1'b1;
        end
  end

  always_comb begin
    w_grant = '0;
    w_hold  = '0;
    if (w_keep) begin
      w_grant = r_grant;
      w_hold  = (r_hold == H_MAX) ? r_hold
                                  : r_hold + 1'b1;
    end else if (|req) begin
      w_grant = w_rr;
      w_hold  = HW'(1);
    end
    w_pat = IDLE_PAT;
    w_blk = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (w_grant[i]) begin
        w_pat = req_pat[4*i +: 4];
        w_blk = req_blink[i];
      end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_row         <= '0;
      r_dot_c       <= '0;
      r_rom_addr    <= {IDLE_PAT, 4'h0};
      r_row_buf     <= 16'hFFFF;
      r_grant       <= '0;
      r_hold        <= '0;
      r_pat_l       <= IDLE_PAT;
      r_blink_l     <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ARB) begin
        r_grant    <= w_grant;
        r_hold     <= w_hold;
        r_pat_l    <= w_pat;
        r_blink_l  <= w_blk;
        r_rom_addr <= {w_pat, 4'h0};
        if (w_grant != r_grant) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == B_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      if (r_state == S_SCAN && r_presc == C_ONE)
        r_row_buf <= rom_data;
      if (r_state != S_SCAN || w_next != S_SCAN) begin
        r_presc <= '0;
        r_row   <= '0;
        r_dot_c <= '0;
      end else if (w_slot_end) begin
        r_presc    <= '0;
        r_row      <= r_row + 1'b1;
        r_dot_c    <= r_row + 1'b1;
        r_rom_addr <= {r_pat_l, r_row + 1'b1};
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign w_show = (r_state == S_SCAN) &&
                  (r_presc >= C_BLANK) &&
                  !(r_blink_l && r_blink_phase);

  assign Dot_R      = w_show ? r_row_buf : 16'hFFFF;
  assign Dot_C      = r_dot_c;
  assign grant      = r_grant;
  assign rom_addr   = r_rom_addr;
  assign frame_tick = (r_state == S_ARB);

endmodule

// File: tb/tb_dot_matrix_scheduler.sv
// Directed bench for dot_matrix_scheduler with a small
// synchronous ROM returning {12'h000, row}.
module tb_dot_matrix_scheduler;

  logic        clock;
  logic        rst_n;
  logic        scan_en;
  logic [1:0]  req;
  logic [7:0]  req_pat;
  logic [1:0]  req_blink;
  logic [1:0]  grant;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] Dot_R;
  logic [3:0]  Dot_C;
  logic        frame_tick;

  int n_chk;
  int n_fail;

  dot_matrix_scheduler #(
    .NREQ        (2),
    .SCAN_DIV    (4),
    .BLANK_CYC   (2),
    .HOLD_FRAMES (2),
    .BLINK_FRAMES(1),
    .IDLE_PAT    (4'd0)
  ) u_dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .scan_en   (scan_en),
    .req       (req),
    .req_pat   (req_pat),
    .req_blink (req_blink),
    .grant     (grant),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .Dot_R     (Dot_R),
    .Dot_C     (Dot_C),
    .frame_tick(frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    rom_data <= {12'h000, rom_addr[3:0]};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("tick_wait", 32'(frame_tick), 32'h1);
  endtask

  // Called at the negedge of an ARB cycle; walks one frame
  // and ends at the negedge of the following ARB cycle.
  task automatic scan_frame(input logic [3:0] pat,
                            input bit         blank,
                            input logic [1:0] g,
                            input int         drop_row,
                            input logic [1:0] drop_req);
    int         c;
    int         r;
    logic [3:0] rr;
    logic [15:0] exp;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      c  = (k - 1) % 4;
      r  = (k - 1) / 4;
      rr = r[3:0];
      if (c == 0) begin
        check("rom_addr", 32'(rom_addr), 32'({pat, rr}));
        check("Dot_C", 32'(Dot_C), 32'(rr));
        check("grant", 32'(grant), 32'(g));
        if (r == drop_row) req = drop_req;
      end
      exp = (c < 2 || blank) ? 16'hFFFF : {12'h000, rr};
      check("Dot_R", 32'(Dot_R), 32'(exp));
      check("tick_low", 32'(frame_tick), 32'h0);
    end
    @(negedge clock);
    check("tick_65", 32'(frame_tick), 32'h1);
    check("arb_dotr", 32'(Dot_R), 32'hFFFF);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    req       = 2'b00;
    req_pat   = 8'h00;
    req_blink = 2'b00;

    repeat (3) @(negedge clock);
    check("rst_dotr", 32'(Dot_R), 32'hFFFF);
    check("rst_dotc", 32'(Dot_C), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_addr", 32'(rom_addr), 32'h00);
    check("rst_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    @(negedge clock);
    check("idle_tick", 32'(frame_tick), 32'h0);
    check("idle_dotr", 32'(Dot_R), 32'hFFFF);

    // Idle pattern, no requesters.
    scan_en = 1'b1;
    wait_tick();
    scan_frame(4'h0, 1'b0, 2'b00, -1, 2'b00);

    // Single requester, pattern 5.
    req     = 2'b01;
    req_pat = {4'hA, 4'h5};
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);

    // Clear ownership, then both request.
    req = 2'b00;
    scan_frame(4'h0, 1'b0, 2'b00, -1, 2'b00);
    req = 2'b11;
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);
    scan_frame(4'hA, 1'b0, 2'b10, -1, 2'b00);
    scan_frame(4'hA, 1'b0, 2'b10, -1, 2'b00);
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);
    // Requester 0 drops mid-frame; grant holds.
    scan_frame(4'h5, 1'b0, 2'b01, 8, 2'b10);
    scan_frame(4'hA, 1'b0, 2'b10, -1, 2'b00);

    // Blink on requester 0.
    req       = 2'b01;
    req_blink = 2'b01;
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);
    scan_frame(4'h5, 1'b1, 2'b01, -1, 2'b00);
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);
    scan_frame(4'h5, 1'b1, 2'b01, -1, 2'b00);
    req_blink = 2'b00;

    // Disable at row 7 c=3.
    repeat (32) @(negedge clock);
    check("r7_dotc", 32'(Dot_C), 32'h7);
    check("r7_dotr", 32'(Dot_R), 32'h0007);
    check("r7_addr", 32'(rom_addr), 32'h57);
    scan_en = 1'b0;
    @(negedge clock);
    check("dis_dotr", 32'(Dot_R), 32'hFFFF);
    check("dis_dotc", 32'(Dot_C), 32'h0);
    check("dis_grant", 32'(grant), 32'h1);
    repeat (3) begin
      @(negedge clock);
      check("dis_hold", 32'(Dot_R), 32'hFFFF);
      check("dis_tick", 32'(frame_tick), 32'h0);
    end
    scan_en = 1'b1;
    @(negedge clock);
    check("reen_tick", 32'(frame_tick), 32'h1);
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);

    // Async reset at row 9 c=2.
    repeat (39) @(negedge clock);
    check("r9_dotr", 32'(Dot_R), 32'h0009);
    #2 rst_n = 1'b0;
    #1;
    check("ar_dotr", 32'(Dot_R), 32'hFFFF);
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_dotc", 32'(Dot_C), 32'h0);
    check("ar_addr", 32'(rom_addr), 32'h00);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    check("ar_idle", 32'(frame_tick), 32'h0);
    @(negedge clock);
    check("ar_arb", 32'(frame_tick), 32'h1);
    scan_frame(4'h5, 1'b0, 2'b01, -1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scheduler.md
Name: dot_matrix_scheduler

Overview:
- Sequences the 16x16 dot-matrix display: row scan timing, inter-row blanking, and pattern fetch from an external synchronous pattern ROM.
- Shares the display between NREQ requesters (lock-state indicator, status icons, etc.) using round-robin with a minimum hold time.
- Drives Dot_R/Dot_C directly and replaces free-running per-pattern scanners.

Parameters:
- NREQ, 2, number of display requesters (2..4)
- SCAN_DIV, 1000, clocks per row slot (> BLANK_CYC)
- BLANK_CYC, 8, blanking cycles at start of each row slot (>= 2)
- HOLD_FRAMES, 25, frames a granted requester keeps display before yielding to a pending requester (>= 1)
- BLINK_FRAMES, 16, frames per blink half-period (>= 1)
- IDLE_PAT, 0, 4-bit pattern id shown when no requester is granted

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- scan_en  in  1  display enable
- req  in  NREQ  display request per requester, level
- req_pat  in  4*NREQ  pattern id per requester, slice i = [4i+3:4i]
- req_blink  in  NREQ  blink request per requester
- grant  out  NREQ  one-hot current owner, 0 = idle pattern
- rom_addr  out  8  {pattern id, row}
- rom_data  in  16  ROM row word, valid one cycle after rom_addr
- Dot_R  out  16  row pixel drive, 1 = dot off
- Dot_C  out  4  active row select
- frame_tick  out  1  one-cycle pulse per frame, in ARB cycle

Behaviour:
- Reset: Dot_R=16'hFFFF, Dot_C=0, grant=0, rom_addr={IDLE_PAT,4'h0}, frame_tick=0. Internal state: IDLE, prescaler=0, row=0, hold=0, blink_cnt=0, blink_phase=0, row_buf=16'hFFFF.
- FSM IDLE -> ARB -> SCAN:
  - IDLE: Dot_R=FFFF, Dot_C=0, counters held at 0. scan_en=1 -> ARB.
  - ARB: exactly 1 cycle. frame_tick=1, Dot_R=FFFF. Arbitration and pattern/blink latch take effect here. Then -> SCAN with row=0, prescaler=0.
  - SCAN: prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1, row increments. At SCAN_DIV-1 of row 15 -> ARB. Frame length = 16*SCAN_DIV+1 cycles.
  - scan_en=0 in any state -> IDLE next cycle. Dot_R=FFFF that cycle onward. grant is kept, hold is kept.
- Row slot timing, with c = prescaler:
  - c=0: Dot_C=row and rom_addr={pat_l,row}, both registered so valid during c=0.
  - c=1: rom_data sampled into row_buf at end of cycle.
  - c<BLANK_CYC: Dot_R=FFFF.
  - c>=BLANK_CYC: Dot_R=row_buf, or FFFF if blanked.
- Arbitration, in ARB only:
  - If the owner's req is high and (hold<HOLD_FRAMES or no other req is high): keep the owner. hold increments, saturating at HOLD_FRAMES.
  - Otherwise grant the first requester with req high, searching round-robin from owner+1 (from index 0 if none). hold=1 on a new grant.
  - No req high: grant=0, hold=0.
  - pat_l = req_pat of the owner, or IDLE_PAT if none. blink_l = req_blink of the owner. Both are frozen for the whole frame, so there is no tearing.
  - A req drop mid-frame has no effect until the next ARB.
- Blink:
  - blink_cnt counts ARB cycles 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
  - When blink_l=1 and blink_phase=1, Dot_R=FFFF for the entire frame; rom fetch still occurs.
  - blink_cnt/blink_phase reset to 0 whenever the owner changes.
- grant changes only in the ARB cycle. It is one-hot or zero at all times.
- rst_n asserted mid-frame: immediate return to reset values, including Dot_R=FFFF asynchronously.

Test Plan:
- Params SCAN_DIV=4, BLANK_CYC=2, HOLD_FRAMES=2, BLINK_FRAMES=1. Reset, scan_en=1, req=0:
  - frame_tick pulses every 65 cycles; rom_addr steps 0x00..0x0F.
  - Dot_R=FFFF for c=0,1 of every slot.
  - grant=0.
- req=01, req_pat[3:0]=5, ROM returns {12'h000,row}: at ARB, grant=01. Row 3 slot shows rom_addr=0x53, and Dot_R=0x0003 at c=2,3.
- req=11 held continuously, with requester 0 granted first: grant sequence over frames is 01,01,10,10,01. A req drop of requester 0 mid-frame 1 keeps grant=01 until the next ARB, then grant=10.
- Requester 0 granted, req_blink=1: Dot_R alternates, a full frame of row data then a full frame of FFFF, toggling at each frame_tick.
- scan_en=0 at row 7 c=3: next cycle Dot_R=FFFF and Dot_C=0. After re-enable, one ARB cycle with frame_tick=1 precedes rom_addr={pat,0}.
- rst_n low during row 9 c=2: Dot_R=FFFF, grant=0, Dot_C=0 immediately. After release, the sequence restarts from IDLE.
